// File: rtl/dmem_responder_if.sv
// Processor data-memory bus between the core (master) and a memory responder (slave).
// Store data, lane mask and read data are LSB-justified on the bus.
interface dmem_responder_if;
  logic [31:0] mem_addr;
  logic        mem_oe;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_ready;

  modport master (
    output mem_addr, mem_oe, mem_wdata, mem_we,
    input  mem_rdata, mem_valid, mem_ready
  );

  modport slave (
    input  mem_addr, mem_oe, mem_wdata, mem_we,
    output mem_rdata, mem_valid, mem_ready
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: local byte-lane RAM with 1-cycle read latency, plus a peripheral
// window forwarded over a level req/ack handshake. Handles byte/halfword lane alignment.
module dmem_responder #(
  parameter int unsigned RAM_AW   = 14,
  parameter logic [3:0]  PER_BASE = 4'hF,
  parameter int unsigned PER_AW   = 12
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic [PER_AW-1:0] per_addr,
  output logic              per_req,
  output logic [3:0]        per_we,
  output logic [31:0]       per_wdata,
  input  logic [31:0]       per_rdata,
  input  logic              per_ack,
  output logic              misalign
);

  localparam int unsigned RamWords = 2 ** (RAM_AW - 2);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e state_q, state_d;

  logic [1:0]        off;
  logic              is_per;
  logic              is_store;
  logic              legal;
  logic              accept;
  logic              per_start;
  logic              per_done;
  logic              ram_rd;
  logic              ram_wr;
  logic [3:0]        lane_mask;
  logic [31:0]       wdata_al;
  logic [RAM_AW-3:0] ram_idx;
  logic              valid_d;
  logic              unused_addr;

  logic [31:0]       ram_q [RamWords];
  logic [31:0]       ram_rd_q;
  logic [1:0]        ram_off_q;
  logic              src_per_q;
  logic [31:0]       per_rd_q;
  logic [1:0]        per_off_q;
  logic [PER_AW-1:0] per_addr_q;
  logic [3:0]        per_we_q;
  logic [31:0]       per_wdata_q;
  logic              valid_q;
  logic              misalign_q;

  // ---------------------------------------------------------------------------
  // Request decode and lane alignment
  // ---------------------------------------------------------------------------
  assign off         = bus.mem_addr[1:0];
  assign is_per      = (bus.mem_addr[31:28] == PER_BASE);
  assign is_store    = |bus.mem_we;
  assign ram_idx     = bus.mem_addr[RAM_AW-1:2];
  assign lane_mask   = bus.mem_we << off;
  assign wdata_al    = bus.mem_wdata << {off, 3'b000};
  assign unused_addr = ^bus.mem_addr;

  // Reads carry no lane mask, so they are always legal.
  always_comb begin
    legal = 1'b0;
    case (bus.mem_we)
      4'b0000, 4'b0001: legal = 1'b1;
      4'b0011:          legal = ~off[0];
      4'b1111:          legal = (off == 2'b00);
      default:          legal = 1'b0;
    endcase
  end

  assign accept    = bus.mem_oe & bus.mem_ready & ~rst;
  assign per_start = accept & is_per & legal;
  assign ram_rd    = accept & ~is_per & ~is_store;
  assign ram_wr    = accept & ~is_per & is_store & legal;
  assign per_done  = (state_q == StWait) & per_ack;
  assign valid_d   = ram_rd | (per_done & (per_we_q == 4'b0000));

  // ---------------------------------------------------------------------------
  // Peripheral FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (per_start) state_d = StWait;
      StWait: if (per_ack)   state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  // Decoded straight from the state register, so mem_ready never sees mem_oe.
  always_comb begin
    bus.mem_ready = 1'b1;
    per_req       = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.mem_ready = 1'b1;
        per_req       = 1'b0;
      end
      StWait: begin
        bus.mem_ready = 1'b0;
        per_req       = 1'b1;
      end
      default: begin
        bus.mem_ready = 1'b1;
        per_req       = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Local RAM: contents survive reset, so no reset on the array or its read port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) begin
          ram_q[ram_idx][8*i +: 8] <= wdata_al[8*i +: 8];
        end
      end
    end
    if (ram_rd) begin
      ram_rd_q <= ram_q[ram_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Response path and peripheral request registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
      ram_off_q   <= 2'b00;
      src_per_q   <= 1'b0;
      per_rd_q    <= '0;
      per_off_q   <= 2'b00;
      per_addr_q  <= '0;
      per_we_q    <= 4'b0000;
      per_wdata_q <= '0;
    end else begin
      valid_q    <= valid_d;
      misalign_q <= accept & ~legal;
      if (ram_rd) begin
        ram_off_q <= off;
        src_per_q <= 1'b0;
      end else if (per_done && per_we_q == 4'b0000) begin
        // Justify at capture so mem_rdata holds steady through later requests.
        per_rd_q  <= per_rdata >> {per_off_q, 3'b000};
        src_per_q <= 1'b1;
      end
      if (per_start) begin
        per_addr_q  <= {bus.mem_addr[PER_AW-1:2], 2'b00};
        per_we_q    <= lane_mask;
        per_wdata_q <= wdata_al;
        per_off_q   <= off;
      end
    end
  end

  assign bus.mem_valid = valid_q;
  assign bus.mem_rdata = src_per_q ? per_rd_q : (ram_rd_q >> {ram_off_q, 3'b000});
  assign misalign      = misalign_q;
  assign per_addr      = per_addr_q;
  assign per_we        = per_we_q;
  assign per_wdata     = per_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: expected read data is queued at issue and
// checked by an independent monitor whenever mem_valid is seen.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] per_addr;
  logic        per_req;
  logic [3:0]  per_we;
  logic [31:0] per_wdata;
  logic [31:0] per_rdata;
  logic        per_ack;
  logic        misalign;

  int          n_checks = 0;
  int          n_errs = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .RAM_AW  (14),
    .PER_BASE(4'hF),
    .PER_AW  (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .per_addr (per_addr),
    .per_req  (per_req),
    .per_we   (per_we),
    .per_wdata(per_wdata),
    .per_rdata(per_rdata),
    .per_ack  (per_ack),
    .misalign (misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Presents one access for a single clock edge; returns 1 time unit after that edge.
  task automatic drive(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
    bus.mem_addr  = addr;
    bus.mem_we    = we;
    bus.mem_wdata = wd;
    bus.mem_oe    = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_oe = 1'b0;
    bus.mem_we = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    drive(addr, 4'b0000, 32'h0);
  endtask

  // Monitor: every mem_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.mem_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(bus.mem_valid), 32'h0);
      end else begin
        chk("rdata", bus.mem_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.mem_addr  = '0;
    bus.mem_oe    = 1'b0;
    bus.mem_we    = 4'b0000;
    bus.mem_wdata = '0;
    per_ack       = 1'b0;
    per_rdata     = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.mem_valid), 32'h0);
    chk("rst_ready", 32'(bus.mem_ready), 32'h1);
    chk("rst_per_req", 32'(per_req), 32'h0);
    chk("rst_per_we", 32'(per_we), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // RAM word store then load
    drive(32'h100, 4'b1111, 32'h1122_3344);
    rd(32'h100, 32'h1122_3344);
    @(negedge clk);
    chk("ready_after_read", 32'(bus.mem_ready), 32'h1);

    // Byte store, then back-to-back reads
    drive(32'h101, 4'b0001, 32'h0000_00AB);
    rd(32'h101, 32'h0011_22AB);
    rd(32'h100, 32'h1122_AB44);

    // Halfword store at offset 2, illegal word store at offset 3
    drive(32'h102, 4'b0011, 32'h0000_BEEF);
    rd(32'h102, 32'h0000_BEEF);
    drive(32'h103, 4'b1111, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("misalign_pulse", 32'(misalign), 32'h1);
    @(negedge clk);
    chk("misalign_clear", 32'(misalign), 32'h0);
    rd(32'h100, 32'hBEEF_AB44);

    // Byte store at the top lane
    drive(32'h104, 4'b1111, 32'h0);
    drive(32'h107, 4'b0001, 32'h0000_0077);
    rd(32'h104, 32'h7700_0000);
    rd(32'h107, 32'h0000_0077);
    drive(32'h200, 4'b1111, 32'h1234_5678);

    // Peripheral read, ack in the third wait cycle
    rd(32'hF000_0014, 32'hCAFE_F00D);
    @(negedge clk);
    chk("pr_req_c1", 32'(per_req), 32'h1);
    chk("pr_ready_c1", 32'(bus.mem_ready), 32'h0);
    chk("pr_addr", 32'(per_addr), 32'h014);
    chk("pr_we", 32'(per_we), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pr_req_c2", 32'(per_req), 32'h1);
    @(posedge clk);
    #1;
    per_ack   = 1'b1;
    per_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("pr_req_c3", 32'(per_req), 32'h1);
    chk("pr_ready_c3", 32'(bus.mem_ready), 32'h0);
    @(posedge clk);
    #1;
    per_ack   = 1'b0;
    per_rdata = '0;
    @(negedge clk);
    chk("pr_req_done", 32'(per_req), 32'h0);
    chk("pr_ready_done", 32'(bus.mem_ready), 32'h1);

    // Peripheral read at offset 2, fastest legal ack
    rd(32'hF000_0016, 32'h0000_CAFE);
    @(negedge clk);
    chk("pr2_addr", 32'(per_addr), 32'h014);
    per_ack   = 1'b1;
    per_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    per_ack = 1'b0;
    @(negedge clk);
    chk("pr2_ready", 32'(bus.mem_ready), 32'h1);

    // Peripheral byte store; accesses during WAIT must be ignored
    drive(32'hF000_0022, 4'b0001, 32'h0000_005A);
    @(negedge clk);
    chk("pw_we", 32'(per_we), 32'h4);
    chk("pw_wdata", per_wdata, 32'h005A_0000);
    chk("pw_addr", 32'(per_addr), 32'h020);
    bus.mem_addr  = 32'h200;
    bus.mem_we    = 4'b1111;
    bus.mem_wdata = 32'h9999_9999;
    bus.mem_oe    = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_we = 4'b0000;
    per_ack    = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_oe = 1'b0;
    per_ack    = 1'b0;
    @(negedge clk);
    chk("pw_req_done", 32'(per_req), 32'h0);
    rd(32'h200, 32'h1234_5678);

    // Illegal peripheral halfword store: no request, misalign pulse
    drive(32'hF000_0001, 4'b0011, 32'h0000_1234);
    @(negedge clk);
    chk("pm_req", 32'(per_req), 32'h0);
    chk("pm_misalign", 32'(misalign), 32'h1);
    chk("pm_ready", 32'(bus.mem_ready), 32'h1);

    // Stray ack while idle
    per_ack = 1'b1;
    @(posedge clk);
    #1;
    per_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT, followed by a late ack
    drive(32'hF000_0008, 4'b0000, 32'h0);
    @(negedge clk);
    chk("rw_req", 32'(per_req), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    per_ack   = 1'b1;
    per_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("rw_req_after", 32'(per_req), 32'h0);
    chk("rw_ready_after", 32'(bus.mem_ready), 32'h1);
    @(posedge clk);
    #1;
    per_ack = 1'b0;
    repeat (3) @(negedge clk);

    chk("pending_reads", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
